// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and sequencing control for the 5-stage MIPS core.
// Stall/flush enables, bypass selects, the HI/LO busy timer and a stall counter.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic             use_rs_d,
    input  logic             use_rt_d,
    input  logic             branch_d,
    input  logic             md_use_d,
    input  logic [4:0]       rs_e,
    input  logic [4:0]       rt_e,
    input  logic [4:0]       wr_e,
    input  logic             regwrite_e,
    input  logic             memtoreg_e,
    input  logic [4:0]       wr_m,
    input  logic             regwrite_m,
    input  logic             memtoreg_m,
    input  logic [4:0]       wr_w,
    input  logic             regwrite_w,
    input  logic             md_start_e,
    input  logic             md_div_e,
    output logic             we_f,
    output logic             we_d,
    output logic             clear_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [5:0] MULT_LD = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LD  = 6'(DIV_CYCLES - 1);

    md_state_t  state, state_nx;
    logic [5:0] cnt, cnt_nx;
    logic       done_nx;

    logic rs_d_e, rt_d_e, rs_d_m, rt_d_m;
    logic rs_e_m, rt_e_m, rs_e_w, rt_e_w;
    logic lw_stall, br_stall, md_stall, stall;

    // Register-number comparisons; $0 never matches anything.
    always_comb begin
        rs_d_e = (rs_d != 5'd0) && (rs_d == wr_e);
        rt_d_e = (rt_d != 5'd0) && (rt_d == wr_e);
        rs_d_m = (rs_d != 5'd0) && (rs_d == wr_m);
        rt_d_m = (rt_d != 5'd0) && (rt_d == wr_m);
        rs_e_m = (rs_e != 5'd0) && (rs_e == wr_m);
        rt_e_m = (rt_e != 5'd0) && (rt_e == wr_m);
        rs_e_w = (rs_e != 5'd0) && (rs_e == wr_w);
        rt_e_w = (rt_e != 5'd0) && (rt_e == wr_w);
    end

    // Stall sources and the resulting pipeline-register controls.
    always_comb begin
        lw_stall = regwrite_e && memtoreg_e &&
                   ((use_rs_d && rs_d_e) || (use_rt_d && rt_d_e));
        br_stall = branch_d &&
                   ((regwrite_e && ((use_rs_d && rs_d_e) ||
                                    (use_rt_d && rt_d_e))) ||
                    (memtoreg_m && ((use_rs_d && rs_d_m) ||
                                    (use_rt_d && rt_d_m))));
        md_stall = md_use_d && (md_busy || md_start_e);
        stall    = lw_stall || br_stall || md_stall;
        we_f     = !stall;
        we_d     = !stall;
        clear_e  = stall;
    end

    // E-stage operand bypass; the younger M result wins over W.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (regwrite_m && rs_e_m)
            fwd_a_e = 2'b10;
        else if (regwrite_w && rs_e_w)
            fwd_a_e = 2'b01;
        if (regwrite_m && rt_e_m)
            fwd_b_e = 2'b10;
        else if (regwrite_w && rt_e_w)
            fwd_b_e = 2'b01;
    end

    // D-stage comparator bypass from a non-load ALU result in M.
    always_comb begin
        fwd_a_d = regwrite_m && !memtoreg_m && rs_d_m;
        fwd_b_d = regwrite_m && !memtoreg_m && rt_d_m;
    end

    // HI/LO timer next state; a start while busy is ignored.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (md_start_e) begin
                    cnt_nx   = md_div_e ? DIV_LD : MULT_LD;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 6'd0) begin
                    cnt_nx = cnt - 6'd1;
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // HI/LO timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            md_done <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            md_done <= done_nx;
        end
    end

    assign md_busy = (state == BUSY);

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a reference model.
module tb_hazard_ctrl;

    localparam int MC = 5;
    localparam int DC = 32;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
    logic [4:0] wr_e = '0, wr_m = '0, wr_w = '0;
    logic use_rs_d = 0, use_rt_d = 0, branch_d = 0, md_use_d = 0;
    logic regwrite_e = 0, memtoreg_e = 0, regwrite_m = 0;
    logic memtoreg_m = 0, regwrite_w = 0, md_start_e = 0, md_div_e = 0;
    logic we_f, we_d, clear_e, fwd_a_d, fwd_b_d, md_busy, md_done;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .branch_d(branch_d), .md_use_d(md_use_d),
        .rs_e(rs_e), .rt_e(rt_e),
        .wr_e(wr_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .wr_m(wr_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .wr_w(wr_w), .regwrite_w(regwrite_w),
        .md_start_e(md_start_e), .md_div_e(md_div_e),
        .we_f(we_f), .we_d(we_d), .clear_e(clear_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int busy_left = 0;
    bit done_m = 0;
    int scnt_m = 0;

    function automatic bit hit(logic [4:0] a, logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic bit d_src_hit(logic [4:0] w);
        return (use_rs_d && hit(rs_d, w)) || (use_rt_d && hit(rt_d, w));
    endfunction

    function automatic int e_sel(logic [4:0] r);
        if (regwrite_m && hit(r, wr_m)) return 2;
        if (regwrite_w && hit(r, wr_w)) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit load_use, branch_dep, md_dep;
        load_use   = regwrite_e && memtoreg_e && d_src_hit(wr_e);
        branch_dep = branch_d && ((regwrite_e && d_src_hit(wr_e)) ||
                                  (memtoreg_m && d_src_hit(wr_m)));
        md_dep     = md_use_d && (busy_left > 0 || md_start_e);
        return load_use || branch_dep || md_dep;
    endfunction

    // Compare DUT against the model on every falling edge, then advance it.
    always @(negedge clk) begin
        bit st;
        if (!rst) begin
            busy_left = 0;
            done_m = 0;
            scnt_m = 0;
        end
        st = model_stall();
        chk("we_f", int'(we_f), int'(!st));
        chk("we_d", int'(we_d), int'(!st));
        chk("clear_e", int'(clear_e), int'(st));
        chk("fwd_a_e", int'(fwd_a_e), e_sel(rs_e));
        chk("fwd_b_e", int'(fwd_b_e), e_sel(rt_e));
        chk("fwd_a_d", int'(fwd_a_d),
            int'(regwrite_m && !memtoreg_m && hit(rs_d, wr_m)));
        chk("fwd_b_d", int'(fwd_b_d),
            int'(regwrite_m && !memtoreg_m && hit(rt_d, wr_m)));
        chk("md_busy", int'(md_busy), int'(busy_left > 0));
        chk("md_done", int'(md_done), int'(done_m));
        chk("stall_cnt", int'(stall_cnt), scnt_m);
        if (rst) begin
            if (st && scnt_m < CMAX) scnt_m++;
            done_m = (busy_left == 1);
            if (busy_left > 0) busy_left--;
            else if (md_start_e) busy_left = md_div_e ? DC : MC;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        wr_e = 0; wr_m = 0; wr_w = 0;
        use_rs_d = 0; use_rt_d = 0; branch_d = 0; md_use_d = 0;
        regwrite_e = 0; memtoreg_e = 0; regwrite_m = 0;
        memtoreg_m = 0; regwrite_w = 0; md_start_e = 0; md_div_e = 0;
    endtask

    task automatic pulse_rst();
        rst = 0;
        cyc();
        rst = 1;
    endtask

    initial begin
        int nb;
        clr_in();
        rst = 0;
        repeat (2) cyc();
        #2;
        chk("rst_busy", int'(md_busy), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        rst = 1;

        // load-use
        cyc(); clr_in();
        regwrite_e = 1; memtoreg_e = 1; wr_e = 2; rs_d = 2; use_rs_d = 1;
        #2;
        chk("lw_we_f", int'(we_f), 0);
        chk("lw_clear", int'(clear_e), 1);
        cyc(); clr_in();
        regwrite_m = 1; memtoreg_m = 1; wr_m = 2; rs_e = 2;
        #2;
        chk("lw_fwd", int'(fwd_a_e), 2);
        chk("lw_nostall", int'(clear_e), 0);

        // register zero
        cyc(); clr_in();
        regwrite_e = 1; memtoreg_e = 1; regwrite_m = 1; regwrite_w = 1;
        rs_d = 0; rt_d = 0; use_rs_d = 1; use_rt_d = 1; branch_d = 1;
        rs_e = 0; rt_e = 0;
        #2;
        chk("r0_stall", int'(clear_e), 0);
        chk("r0_fa", int'(fwd_a_e), 0);
        chk("r0_fb", int'(fwd_b_e), 0);
        chk("r0_fd", int'(fwd_a_d), 0);

        // M over W priority
        cyc(); clr_in();
        rs_e = 5; regwrite_m = 1; wr_m = 5; regwrite_w = 1; wr_w = 5;
        #2;
        chk("prio_m", int'(fwd_a_e), 2);
        regwrite_m = 0;
        #1;
        chk("prio_w", int'(fwd_a_e), 1);

        // branch dependency chain on $7
        cyc(); clr_in();
        branch_d = 1; rs_d = 7; use_rs_d = 1; regwrite_e = 1; wr_e = 7;
        #2;
        chk("br_e", int'(clear_e), 1);
        cyc(); clr_in();
        branch_d = 1; rs_d = 7; use_rs_d = 1; regwrite_m = 1; wr_m = 7;
        #2;
        chk("br_fwd", int'(fwd_a_d), 1);
        chk("br_nostall", int'(clear_e), 0);
        memtoreg_m = 1;
        #1;
        chk("br_load", int'(clear_e), 1);

        // mult followed by mflo
        cyc(); clr_in();
        pulse_rst();
        md_start_e = 1; md_use_d = 1;
        #2;
        chk("mul_start_stall", int'(clear_e), 1);
        chk("mul_start_busy", int'(md_busy), 0);
        for (int i = 0; i < MC; i++) begin
            cyc();
            md_start_e = 0;
            #2;
            chk("mul_busy", int'(md_busy), 1);
            chk("mul_stall", int'(clear_e), 1);
        end
        cyc();
        #2;
        chk("mul_end_busy", int'(md_busy), 0);
        chk("mul_done", int'(md_done), 1);
        chk("mul_cnt", int'(stall_cnt), 6);
        cyc(); md_use_d = 0;
        #2;
        chk("mul_done_once", int'(md_done), 0);

        // div aborted by reset on busy cycle 10
        cyc(); clr_in();
        pulse_rst();
        md_start_e = 1; md_div_e = 1; md_use_d = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            md_start_e = 0; md_div_e = 0;
        end
        rst = 0;
        #1;
        chk("abort_busy", int'(md_busy), 0);
        chk("abort_cnt", int'(stall_cnt), 0);
        chk("abort_done", int'(md_done), 0);
        cyc();
        #2;
        chk("abort_done2", int'(md_done), 0);
        cyc(); clr_in();
        rst = 1;
        md_start_e = 1;
        cyc(); md_start_e = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (md_busy) nb++;
            cyc();
        end
        chk("post_abort_busy_len", nb, MC);

        // randomized traffic
        clr_in();
        for (int i = 0; i < 4000; i++) begin
            cyc();
            rst = ($urandom_range(0, 299) != 0);
            rs_d = 5'($urandom_range(0, 3));
            rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3));
            rt_e = 5'($urandom_range(0, 3));
            wr_e = 5'($urandom_range(0, 3));
            wr_m = 5'($urandom_range(0, 3));
            wr_w = 5'($urandom_range(0, 3));
            use_rs_d = 1'($urandom);
            use_rt_d = 1'($urandom);
            branch_d = ($urandom_range(0, 3) == 0);
            md_use_d = ($urandom_range(0, 2) == 0);
            regwrite_e = 1'($urandom);
            memtoreg_e = 1'($urandom);
            regwrite_m = 1'($urandom);
            memtoreg_m = 1'($urandom);
            regwrite_w = 1'($urandom);
            md_start_e = ($urandom_range(0, 7) == 0);
            md_div_e = 1'($urandom);
        end
        cyc();
        rst = 1;
        clr_in();
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
